byte_uart_tx: RTL
=================

BYTE_UART_TX -- requirements
Module: byte_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the number of byte entries in the FIFO; legal values are powers of two, at least 2.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port resetn, input, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_byte, input, width 8: write data from the CPU's out_byte register.
REQ-006 SHALL have port in_byte_en, input, width 1: one-cycle write strobe from the CPU's out_byte_en.
REQ-007 SHALL have port tx, output, width 1: the UART serial line, idle high.
REQ-008 SHALL have port busy, output, width 1: high when the FSM is not IDLE or the FIFO is non-empty.
REQ-009 SHALL have port fifo_level, output, width $clog2(FIFO_DEPTH)+1: the number of bytes held in the FIFO.
REQ-010 SHALL have port overflow, output, width 1: sticky flag set when a byte is dropped.

Function
REQ-011 SHALL sample in_byte into the FIFO on a rising edge where in_byte_en=1 and the FIFO is not full; each strobe cycle is one write.
REQ-012 SHALL drop the byte and set overflow when in_byte_en=1, the FIFO is full, and no pop occurs in the same cycle.
REQ-013 SHALL accept the write when the FIFO is full and a pop occurs in the same cycle; fifo_level is then unchanged.
REQ-014 SHALL update fifo_level on each edge as +1 for write-only, -1 for pop-only, and unchanged for both or neither.
REQ-015 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP; PARITY exists only when the macro in REQ-028 is defined.
REQ-017 SHALL pop the FIFO head into the shift register and enter START when the FSM is in IDLE and fifo_level>0.
REQ-018 SHALL drive tx=0 for START, data bits LSB first for DATA, and tx=1 for STOP and IDLE.
REQ-019 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded to CLKS_PER_BIT-1 at each bit start.
REQ-020 SHALL make DATA last exactly 8 bit periods, tracked by a 3-bit index.
REQ-021 SHALL, at the end of STOP, pop the next byte and enter START with no idle bit if fifo_level>0; otherwise it SHALL enter IDLE.
REQ-022 SHALL drive tx low on the 2nd rising edge after a strobe sampled while IDLE with an empty FIFO (latency 2 cycles).
REQ-023 SHALL register tx directly from a flop, with no combinational path from inputs.
REQ-024 SHALL hold overflow at 1 until reset once set.

Reset
REQ-025 SHALL, while resetn=0, force tx=1, busy=0, fifo_level=0, overflow=0, the FSM to IDLE, and the FIFO pointers and counters to 0.
REQ-026 SHALL abort an in-flight frame on reset mid-frame, with tx returning high asynchronously and all FIFO contents discarded.
REQ-027 SHALL ignore strobes during reset; the first edge with resetn=1 may accept a write.

Configuration
REQ-028 SHALL support macro BYTE_UART_TX_PARITY_EN; when defined, a PARITY state of one bit period carrying even parity (XOR of the 8 data bits) SHALL follow DATA, giving an 11-bit frame.
REQ-029 SHALL, when BYTE_UART_TX_PARITY_EN is undefined, go DATA->STOP directly with a 10-bit frame (8N1) and synthesise no parity logic.

Verification
REQ-030 SHALL verify: with CLKS_PER_BIT=4 and no parity, write 0x55 while idle -> tx low 2 edges later, then 1,0,1,0,1,0,1,0 for 4 cycles each, stop high, busy falls 40 cycles after tx fell.
REQ-031 SHALL verify: write 0x41 then 0x42 back-to-back -> two frames with no idle gap (stop bit of 0x41 immediately followed by start bit of 0x42), fifo_level peaks at 1.
REQ-032 SHALL verify: with FIFO_DEPTH=4, 6 consecutive strobes 0x01..0x06 while idle -> 0x01 popped, 0x02..0x05 queued, 0x06 dropped, overflow=1, transmitted bytes are 01..05.
REQ-033 SHALL verify: a strobe on the same edge as a pop with the FIFO full -> byte accepted, fifo_level stays at FIFO_DEPTH, overflow stays 0.
REQ-034 SHALL verify: resetn pulsed low mid-DATA of byte 0xA5 -> tx=1 immediately, fifo_level=0, a subsequent write of 0x3C transmits a clean frame.
REQ-035 SHALL verify: with BYTE_UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 after bit 7, frame 44 cycles at CLKS_PER_BIT=4; write 0x03 -> parity bit 0.

Source files
------------

// File: rtl/byte_uart_tx.sv
// byte_uart_tx: FIFO-buffered 8-bit UART transmitter, 8N1 by default.
// Build option: define BYTE_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Ports:
//   clk        - clock; all state updates on its rising edge
//   resetn     - asynchronous active-low reset
//   in_byte    - write data
//   in_byte_en - one-cycle write strobe
//   tx         - serial line, idle high, driven straight from a flop
//   busy       - frame in flight or bytes still queued
//   fifo_level - bytes currently held in the FIFO
//   overflow   - sticky, set when a strobe hits a full FIFO with no pop
module byte_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [7:0]                  in_byte,
    input  logic                        in_byte_en,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef BYTE_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
`ifdef BYTE_UART_TX_PARITY_EN
    logic          parity_q;
`endif
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q;
    logic          bit_end, full, pop, push;

    always_comb begin
        bit_end = cnt_q == 16'd0;
        full    = level_q == LW'(FIFO_DEPTH);
        // A pop happens when idle, or exactly at the last cycle of STOP so frames abut.
        pop     = level_q != '0 && (state_q == IDLE || (state_q == STOP && bit_end));
        // A full FIFO still takes a write when the same edge frees a slot.
        push    = in_byte_en && (!full || pop);
        level_d = (push && !pop) ? level_q + LW'(1) :
                  (pop && !push) ? level_q - LW'(1) : level_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_byte;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= push ? wr_q + AW'(1) : wr_q;
            rd_q    <= pop ? rd_q + AW'(1) : rd_q;
            level_q <= level_d;
            ovf_q   <= ovf_q | (in_byte_en && full && !pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef BYTE_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // Bit timer free-runs down to zero; every bit boundary below reloads it.
            if (!bit_end) cnt_q <= cnt_q - 16'd1;
            if (pop) begin
                shift_q  <= mem_q[rd_q];
                state_q  <= START;
                cnt_q    <= BIT_RELOAD;
                tx_q     <= 1'b0;
`ifdef BYTE_UART_TX_PARITY_EN
                parity_q <= ^mem_q[rd_q];
`endif
            end else if (bit_end) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        cnt_q   <= BIT_RELOAD;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                    DATA: begin
                        cnt_q <= BIT_RELOAD;
                        if (idx_q == 3'd7) begin
`ifdef BYTE_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // shift_q[0] is the bit on the line; shift_q[1] is next.
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
`ifdef BYTE_UART_TX_PARITY_EN
                    PARITY: begin
                        state_q <= STOP;
                        cnt_q   <= BIT_RELOAD;
                        tx_q    <= 1'b1;
                    end
`endif
                    STOP: state_q <= IDLE;
                    default: tx_q <= 1'b1;
                endcase
            end
        end
    end

    assign tx         = tx_q;
    assign busy       = state_q != IDLE || level_q != '0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
endmodule
